// File: rtl/fc_score_collector.sv
// Packs the FC layer's streamed class scores into one vector, optionally accumulating
// partial sums over NUM_PASS passes with signed saturation, and hands it off via valid/ready.
module fc_score_collector #(
  parameter int NUM_CLASS = 10,
  parameter int DATA_W    = 16,
  parameter int NUM_PASS  = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_clear,
  input  logic                          i_in_valid,
  input  logic [DATA_W-1:0]             i_in_data,
  output logic                          o_in_ready,
  output logic                          o_out_valid,
  output logic [NUM_CLASS*DATA_W-1:0]   o_out_data,
  input  logic                          i_out_ready
);

  localparam int CLS_W  = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam int PASS_W = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
  localparam logic [CLS_W-1:0]  CLS_LAST  = CLS_W'(NUM_CLASS - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASS - 1);
  localparam logic [DATA_W-1:0] SAT_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  // S_COLLECT | accepting scores into slot cls_cnt of pass pass_cnt
  // S_FULL    | frame complete, held on o_out_data until downstream takes it
  typedef enum logic {S_COLLECT, S_FULL} state_t;

  state_t                              r_state;
  state_t                              w_next_state;
  logic [CLS_W-1:0]                    r_cls_cnt;
  logic [PASS_W-1:0]                   r_pass_cnt;
  logic [NUM_CLASS-1:0][DATA_W-1:0]    r_slots;

  logic                                w_accept;
  logic                                w_last_cls;
  logic                                w_last_pass;
  logic [DATA_W-1:0]                   w_cur;
  logic [DATA_W:0]                     w_sum;
  logic [DATA_W-1:0]                   w_sat;
  logic [DATA_W-1:0]                   w_wr;

  assign o_in_ready  = (r_state == S_COLLECT);
  assign o_out_valid = (r_state == S_FULL);
  assign o_out_data  = r_slots;

  assign w_accept    = i_in_valid & o_in_ready;
  assign w_last_cls  = (r_cls_cnt == CLS_LAST);
  assign w_last_pass = (r_pass_cnt == PASS_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_COLLECT;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (i_clear) begin
      w_next_state = S_COLLECT;
    end else begin
      case (r_state)
        S_COLLECT: if (w_accept && w_last_cls && w_last_pass) w_next_state = S_FULL;
        S_FULL:    if (i_out_ready) w_next_state = S_COLLECT;
        default:   w_next_state = S_COLLECT;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cls_cnt  <= '0;
      r_pass_cnt <= '0;
    end else if (i_clear) begin
      r_cls_cnt  <= '0;
      r_pass_cnt <= '0;
    end else if (w_accept) begin
      if (w_last_cls) begin
        r_cls_cnt  <= '0;
        r_pass_cnt <= w_last_pass ? '0 : r_pass_cnt + 1'b1;
      end else begin
        r_cls_cnt  <= r_cls_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_cur = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (r_cls_cnt == CLS_W'(k)) w_cur = r_slots[k];
    end
  end

  // Sign-extend both operands by one bit; overflow shows as the top two sum bits disagreeing.
  assign w_sum = {w_cur[DATA_W-1], w_cur} + {i_in_data[DATA_W-1], i_in_data};

  always_comb begin
    w_sat = w_sum[DATA_W-1:0];
    if (w_sum[DATA_W] != w_sum[DATA_W-1]) w_sat = w_sum[DATA_W] ? SAT_MIN : SAT_MAX;
  end

  assign w_wr = (r_pass_cnt == '0) ? i_in_data : w_sat;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slots <= '0;
    end else if (i_clear) begin
      r_slots <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < NUM_CLASS; k++) begin
        if (r_cls_cnt == CLS_W'(k)) r_slots[k] <= w_wr;
      end
    end
  end

endmodule

// File: tb/tb_fc_score_collector.sv
// Randomized bench for fc_score_collector: instance 0 is single-pass, instance 1 accumulates two passes.
module tb_fc_score_collector;
  localparam int NC = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst       [2];
  logic            clear     [2];
  logic            in_valid  [2];
  logic [DW-1:0]   in_data   [2];
  logic            in_ready  [2];
  logic            out_valid [2];
  logic [NC*DW-1:0] out_data [2];
  logic            out_ready [2];

  int n_tests = 0;
  int n_fail  = 0;

  fc_score_collector #(.NUM_CLASS(NC), .DATA_W(DW), .NUM_PASS(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst[0]), .i_clear(clear[0]), .i_in_valid(in_valid[0]),
    .i_in_data(in_data[0]), .o_in_ready(in_ready[0]), .o_out_valid(out_valid[0]),
    .o_out_data(out_data[0]), .i_out_ready(out_ready[0]));

  fc_score_collector #(.NUM_CLASS(NC), .DATA_W(DW), .NUM_PASS(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst[1]), .i_clear(clear[1]), .i_in_valid(in_valid[1]),
    .i_in_data(in_data[1]), .o_in_ready(in_ready[1]), .o_out_valid(out_valid[1]),
    .o_out_data(out_data[1]), .i_out_ready(out_ready[1]));

  task automatic check_eq(input string tag, input logic [NC*DW-1:0] obs, input logic [NC*DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference frame: slot k = saturating running sum of the k-th score of every pass.
  function automatic logic [NC*DW-1:0] pack_exp(input int sc[$], input int np);
    logic [NC*DW-1:0] r;
    int acc;
    r = '0;
    for (int k = 0; k < NC; k++) begin
      acc = sc[k];
      for (int p = 1; p < np; p++) acc = sat(acc + sc[p*NC + k]);
      r[DW*k +: DW] = DW'(acc);
    end
    return r;
  endfunction

  function automatic int rnd_score(input bit wide);
    logic signed [DW-1:0] s;
    s = DW'($urandom);
    if (!wide) s = DW'($urandom_range(200)) - 16'sd100;
    return int'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int d, input int sc[$], input int gap_pct, input int hold);
    int np;
    int ng;
    logic [NC*DW-1:0] exp_v;
    np = (d == 0) ? 1 : 2;
    exp_v = pack_exp(sc, np);
    for (int i = 0; i < sc.size(); i++) begin
      ng = ($urandom_range(99) < gap_pct) ? $urandom_range(1, 3) : 0;
      for (int g = 0; g < ng; g++) begin
        in_valid[d] = 1'b0;
        in_data[d]  = DW'($urandom);
        tick();
        check_eq("idle_ready", in_ready[d], 1);
        check_eq("idle_valid", out_valid[d], 0);
      end
      in_valid[d] = 1'b1;
      in_data[d]  = DW'(sc[i]);
      tick();
      check_eq("acc_out_valid", out_valid[d], (i == sc.size() - 1));
      check_eq("acc_in_ready",  in_ready[d],  (i != sc.size() - 1));
    end
    check_eq("frame_data", out_data[d], exp_v);
    out_ready[d] = 1'b0;
    for (int h = 0; h < hold; h++) begin
      in_valid[d] = h[0];
      in_data[d]  = DW'($urandom);
      tick();
      check_eq("hold_valid", out_valid[d], 1);
      check_eq("hold_ready", in_ready[d], 0);
      check_eq("hold_data",  out_data[d], exp_v);
    end
    out_ready[d] = 1'b1;
    in_valid[d]  = 1'b1;
    in_data[d]   = DW'($urandom);
    tick();
    check_eq("hs_valid", out_valid[d], 0);
    check_eq("hs_ready", in_ready[d], 1);
    check_eq("hs_data",  out_data[d], exp_v);
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b0;
  endtask

  task automatic partial(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid[d] = 1'b1;
      in_data[d]  = DW'($urandom);
      tick();
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic rand_frame(input int d, input int gap_pct, input int hold);
    int sc[$];
    int np;
    np = (d == 0) ? 1 : 2;
    for (int i = 0; i < NC*np; i++) sc.push_back(rnd_score($urandom_range(1) == 1));
    send_frame(d, sc, gap_pct, hold);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    int sc[$];
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; clear[d] = 1'b0; in_valid[d] = 1'b0;
      in_data[d] = '0; out_ready[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_valid", out_valid[d], 0);
      check_eq("rst_ready", in_ready[d], 1);
      check_eq("rst_data",  out_data[d], 0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();

    // single pass, then backpressure, then stalled stream with the same scores
    sc = {};
    for (int i = 1; i <= NC; i++) sc.push_back(i);
    send_frame(0, sc, 0, 0);
    check_eq("sp_const", out_data[0], {16'd10, 16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
    send_frame(0, sc, 0, 5);
    send_frame(0, sc, 50, 0);
    check_eq("stall_const", out_data[0], {16'd10, 16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});

    // two-pass accumulation with saturation in both directions
    sc = {};
    for (int i = 0; i < 2*NC; i++) sc.push_back(0);
    sc[0] = 30000;  sc[1] = -30000;  sc[2] = -5;
    sc[NC] = 10000; sc[NC+1] = -10000; sc[NC+2] = 7;
    send_frame(1, sc, 0, 2);
    check_eq("acc_slot0", out_data[1][15:0],  16'h7FFF);
    check_eq("acc_slot1", out_data[1][31:16], 16'h8000);
    check_eq("acc_slot2", out_data[1][47:32], 16'd2);
    check_eq("acc_rest",  out_data[1][159:48], 0);

    // clear mid-frame with a coincident accept
    partial(0, 4);
    clear[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 16'h1234;
    tick();
    clear[0] = 1'b0; in_valid[0] = 1'b0;
    check_eq("clr_data",  out_data[0], 0);
    check_eq("clr_ready", in_ready[0], 1);
    check_eq("clr_valid", out_valid[0], 0);
    rand_frame(0, 20, 1);

    // clear while holding a finished frame
    partial(1, 2*NC);
    check_eq("clrfull_pre", out_valid[1], 1);
    clear[1] = 1'b1;
    tick();
    clear[1] = 1'b0;
    check_eq("clrfull_valid", out_valid[1], 0);
    check_eq("clrfull_ready", in_ready[1], 1);
    check_eq("clrfull_data",  out_data[1], 0);
    rand_frame(1, 20, 1);

    // asynchronous reset between edges, mid-frame and in FULL
    partial(0, 6);
    #3 rst[0] = 1'b1;
    #1;
    check_eq("arst_valid", out_valid[0], 0);
    check_eq("arst_ready", in_ready[0], 1);
    check_eq("arst_data",  out_data[0], 0);
    #1 rst[0] = 1'b0;
    tick();
    rand_frame(0, 0, 0);
    partial(1, 2*NC);
    #3 rst[1] = 1'b1;
    #1;
    check_eq("arst2_valid", out_valid[1], 0);
    check_eq("arst2_data",  out_data[1], 0);
    #1 rst[1] = 1'b0;
    tick();

    for (int n = 0; n < 6; n++) begin
      rand_frame(0, $urandom_range(40), $urandom_range(3));
      rand_frame(1, $urandom_range(40), $urandom_range(3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
